// File: rtl/ser_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit,
// each bit held for DIV clock cycles. tx and busy are registered; ready is combinational.
//   state | meaning
//   IDLE  | line high, waiting for valid
//   START | driving start bit (0)
//   DATA  | driving shreg[0], shifting on each bit end
//   STOP  | driving stop bit (1)
module ser_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;

    assign ready   = (state_q == IDLE) && !rst;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign bit_end = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            IDLE: begin
                if (valid && ready) begin
                    shreg_d   = data;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START, DATA, STOP: begin
                div_cnt_d = bit_end ? '0 : div_cnt_q + DCW'(1);
                if (bit_end) begin
                    if (state_q == START) begin
                        state_d = DATA;
                    end else if (state_q == DATA) begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered, so it is derived from the state being entered
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_ser_tx.sv
// Scoreboard bench for ser_tx: two instances (W8/D4 and W4/D1); expected
// per-cycle {tx,busy} pairs are queued when a word is accepted.
module tb_ser_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, valid0, ready0, tx0, busy0;
    logic [7:0] data0;
    logic       rst1, valid1, ready1, tx1, busy1;
    logic [3:0] data1;

    ser_tx #(.WIDTH(8), .DIV(4)) dut0 (
        .clk(clk), .rst(rst0), .data(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0)
    );
    ser_tx #(.WIDTH(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .data(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int rem0 = 0;
    int rem1 = 0;
    logic [1:0] sb0[$];
    logic [1:0] sb1[$];
    int rises0[$];
    logic prev_busy0 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic tick();
        logic [1:0] e;
        @(negedge clk);
        check_eq("ready0", {31'b0, ready0}, {31'b0, (!rst0 && rem0 == 0)});
        check_eq("ready1", {31'b0, ready1}, {31'b0, (!rst1 && rem1 == 0)});
        if (rst0) begin
            sb0.delete(); rem0 = 0;
        end else if (rem0 > 0) begin
            rem0--;
        end else if (valid0) begin
            for (int i = 0; i < 4; i++) sb0.push_back(2'b01);
            for (int k = 0; k < 8; k++)
                for (int i = 0; i < 4; i++) sb0.push_back({data0[k], 1'b1});
            for (int i = 0; i < 4; i++) sb0.push_back(2'b11);
            rem0 = 40;
        end
        if (rst1) begin
            sb1.delete(); rem1 = 0;
        end else if (rem1 > 0) begin
            rem1--;
        end else if (valid1) begin
            sb1.push_back(2'b01);
            for (int k = 0; k < 4; k++) sb1.push_back({data1[k], 1'b1});
            sb1.push_back(2'b11);
            rem1 = 6;
        end
        @(posedge clk);
        #1;
        cycle++;
        e = (sb0.size() > 0) ? sb0.pop_front() : 2'b10;
        check_eq("tx0", {31'b0, tx0}, {31'b0, e[1]});
        check_eq("busy0", {31'b0, busy0}, {31'b0, e[0]});
        e = (sb1.size() > 0) ? sb1.pop_front() : 2'b10;
        check_eq("tx1", {31'b0, tx1}, {31'b0, e[1]});
        check_eq("busy1", {31'b0, busy1}, {31'b0, e[0]});
        if (busy0 && !prev_busy0) rises0.push_back(cycle);
        prev_busy0 = busy0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; valid0 = 1'b1; valid1 = 1'b1;
        data0 = 8'hA5; data1 = 4'h0;
        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        tick();

        // single frame 0xA5
        data0 = 8'hA5; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (41) tick();

        // back-to-back 0x00 then 0xFF with valid held
        rises0.delete();
        data0 = 8'h00; valid0 = 1'b1;
        tick();
        data0 = 8'hFF;
        repeat (41) tick();
        valid0 = 1'b0;
        repeat (42) tick();
        check_eq("b2b_frames", rises0.size(), 2);
        if (rises0.size() >= 2) check_eq("b2b_spacing", rises0[1] - rises0[0], 41);

        // data changes every cycle after accepting 0x3C
        data0 = 8'h3C; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        for (int i = 0; i < 41; i++) begin
            data0 = 8'($urandom);
            tick();
        end

        // DIV=1, WIDTH=4, data 0x9
        data1 = 4'h9; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        repeat (7) tick();

        // reset during data bit 3, then a clean 0x81 frame
        data0 = 8'($urandom); valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (17) tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        data0 = 8'h81; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (42) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
